sram_rw_port_ctrl: RTL and testbench

- Initiator-side controller for a single-port synchronous RW SRAM macro (RW0_* interface).
- The macro has 1-cycle read latency, per-granule write mask, and `RW0_rdata` that is valid only in the cycle after a read.
- Presents a valid/ready request channel and a valid/ready read-response channel to a cache or directory client.
- Zero-initialises the whole array after reset.
- Sits between client pipeline logic and the `*_ext` SRAM instance.

---
 rtl/sram_rw_port_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: initiator-side controller for a single-port synchronous
// RW SRAM macro (1-cycle read latency, per-granule write mask).
// Presents a valid/ready request channel and a valid/ready read-response
// channel, and zero-fills the whole array after reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | zero-fill sweep, one word per cycle, requests blocked
// ST_RUN  | client requests pass straight through to the macro
module sram_rw_port_ctrl #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 64,
  parameter int MASK_W        = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_sweep;
  logic              w_run;
  logic              w_pop;
  logic              w_push;
  logic              w_acc;
  logic              w_rd_acc;
  logic [1:0]        w_credits;

  // The sweep is gated by reset_n so the macro stays idle while reset is held.
  assign w_sweep   = (r_state == ST_INIT) & reset_n;
  // init_done also masks the RUN state during reset when the sweep is skipped.
  assign w_run     = (r_state == ST_RUN) & r_init_done;
  assign resp_valid = (r_count != 2'd0);
  assign resp_rdata = r_buf[r_rptr];
  assign init_done  = r_init_done;
  assign w_pop      = resp_valid & resp_ready;
  assign w_push     = r_inflight;
  // A credit is held from read acceptance until the response is popped.
  assign w_credits  = r_count + {1'b0, r_inflight};
  assign req_ready  = w_run & ((w_credits < 2'd2) | w_pop);
  assign w_acc      = req_valid & req_ready;
  assign w_rd_acc   = w_acc & ~req_write;

  // Macro port mux: sweep writes zeros with a full mask, otherwise the
  // accepted request is passed through in the same cycle.
  always_comb begin
    RW0_en = w_sweep | w_acc;
    if (w_sweep) begin
      RW0_addr  = r_init_cnt;
      RW0_wmode = 1'b1;
      RW0_wmask = '1;
      RW0_wdata = '0;
    end else begin
      RW0_addr  = req_addr;
      RW0_wmode = req_write;
      RW0_wmask = req_wmask;
      RW0_wdata = req_wdata;
    end
  end

  // Init/run state machine and zero-fill address counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // Read tracking: in-flight flag and response FIFO pointers/occupancy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_rd_acc;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // Response storage: macro read data is only valid in the cycle after the
  // read, so it is captured exactly then.
  always_ff @(posedge clock) begin
    if (w_push) r_buf[r_wptr] <= RW0_rdata;
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Testbench for sram_rw_port_ctrl: behavioural SRAM macro plus a reference
// model (word array + queue of expected read responses).
module tb_sram_rw_port_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int GW     = DATA_W / MASK_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM macro model: read data appears one cycle after the read, garbage otherwise.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic [DATA_W-1:0] sram_mrg;
  always @(posedge clock) begin
    if (RW0_en === 1'b1 && RW0_wmode === 1'b1) begin
      sram_mrg = sram_mem[RW0_addr];
      for (int g = 0; g < MASK_W; g++)
        if (RW0_wmask[g]) sram_mrg[g*GW +: GW] = RW0_wdata[g*GW +: GW];
      sram_mem[RW0_addr] <= sram_mrg;
    end
    if (RW0_en === 1'b1 && RW0_wmode === 1'b0) RW0_rdata <= sram_mem[RW0_addr];
    else RW0_rdata <= {$urandom(), $urandom()};
  end

  // Reference model
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] expq [$];
  int checks;
  int errors;

  // Per-cycle observations, sampled at the falling edge
  logic              t_acc, t_pop, t_ready, t_rvalid, t_init_done;
  logic              t_en, t_wmode;
  logic [ADDR_W-1:0] t_addr;
  logic [MASK_W-1:0] t_wmask;
  logic [DATA_W-1:0] t_wdata, t_rdata;
  logic              t_w;
  logic [ADDR_W-1:0] t_a;
  logic [DATA_W-1:0] t_d;
  logic [MASK_W-1:0] t_m;
  int                t_out;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o,
                                              input logic [DATA_W-1:0] n,
                                              input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = o;
    for (int g = 0; g < MASK_W; g++) if (m[g]) r[g*GW +: GW] = n[g*GW +: GW];
    return r;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
  endtask

  // One clock cycle: sample at negedge, update the model, return 1 after posedge.
  task automatic tick();
    @(negedge clock);
    t_ready = req_ready; t_rvalid = resp_valid; t_init_done = init_done;
    t_acc = req_valid & req_ready;
    t_pop = resp_valid & resp_ready;
    t_rdata = resp_rdata;
    t_en = RW0_en; t_wmode = RW0_wmode; t_addr = RW0_addr;
    t_wmask = RW0_wmask; t_wdata = RW0_wdata;
    t_w = req_write; t_a = req_addr; t_d = req_wdata; t_m = req_wmask;
    t_out = expq.size();
    if (t_acc === 1'b1) begin
      if (req_write) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
      else expq.push_back(ref_mem[req_addr]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (t_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", t_ready); end
    checks++; if (t_rvalid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", t_rvalid); end
    checks++; if (t_en !== 1'b0) begin errors++; $display("FAIL reset_rw0_en got %b want 0", t_en); end
    checks++; if (t_init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", t_init_done); end
  endtask

  // Releases reset and checks a complete zero-fill sweep from address 0.
  task automatic test_init_sweep();
    int bad;
    int first_bad;
    bad = 0; first_bad = -1;
    drive(1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (t_en !== 1'b1 || t_wmode !== 1'b1 || t_addr !== ADDR_W'(i) || t_wdata !== '0 ||
          t_wmask !== {MASK_W{1'b1}} || t_ready !== 1'b0 || t_init_done !== 1'b0) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_sweep bad_cycles %0d (first %0d) want 0", bad, first_bad); end
    tick();
    checks++; if (t_init_done !== 1'b1) begin errors++; $display("FAIL init_done_after_sweep got %b want 1", t_init_done); end
    checks++; if (t_en !== 1'b0) begin errors++; $display("FAIL sweep_length rw0_en after 512 got %b want 0", t_en); end
    checks++; if (t_ready !== 1'b1) begin errors++; $display("FAIL run_req_ready got %b want 1", t_ready); end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] e;
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 9'h005, 64'h1122334455667788, 8'hFF);
    tick();
    checks++; if (t_acc !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", t_acc); end
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    tick();
    checks++; if (t_acc !== 1'b1) begin errors++; $display("FAIL rd_accept got %b want 1", t_acc); end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    checks++; if (t_rvalid !== 1'b0) begin errors++; $display("FAIL rd_latency_n1 resp_valid got %b want 0", t_rvalid); end
    if (t_pop === 1'b1 && expq.size() > 0) e = expq.pop_front();
    tick();
    checks++; if (t_rvalid !== 1'b1) begin errors++; $display("FAIL rd_latency_n2 resp_valid got %b want 1", t_rvalid); end
    checks++; if (t_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data got %h want 1122334455667788", t_rdata); end
    if (t_pop === 1'b1 && expq.size() > 0) e = expq.pop_front();
  endtask

  task automatic test_masked_write();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] got;
    bit seen;
    seen = 0; got = '0;
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 9'h005, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    tick();
    drive(1'b1, 1'b0, 9'h005, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (t_pop === 1'b1) begin
        seen = 1; got = t_rdata;
        if (expq.size() > 0) e = expq.pop_front();
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL masked_resp timeout got none want 1 response"); end
    checks++; if (got !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL masked_data got %h want 11223344ffffffff", got); end
  endtask

  task automatic test_backpressure();
    int k;
    int got;
    logic [DATA_W-1:0] e;
    resp_ready = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      drive(1'b1, 1'b1, ADDR_W'(a), {$urandom(), $urandom()}, 8'hFF);
      tick();
    end
    resp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, ADDR_W'(k + 1), '0, '0);
      tick();
      if (t_acc === 1'b1) k++;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", k); end
    checks++; if (t_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready got %b want 0", t_ready); end
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && !(k == 4 && expq.size() == 0); c++) begin
      drive(k < 4, 1'b0, ADDR_W'(k + 1), '0, '0);
      tick();
      if (t_acc === 1'b1) k++;
      if (t_pop === 1'b1) begin
        got++;
        if (expq.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra_resp got %h want none", t_rdata);
        end else begin
          e = expq.pop_front();
          checks++; if (t_rdata !== e) begin errors++; $display("FAIL bp_resp%0d got %h want %h", got, t_rdata, e); end
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    checks++; if (got != 4) begin errors++; $display("FAIL bp_resp_count got %0d want 4", got); end
    checks++; if (k != 4) begin errors++; $display("FAIL bp_total_accepted got %0d want 4", k); end
  endtask

  task automatic test_streaming();
    int pops;
    int not_ready;
    int late;
    logic [DATA_W-1:0] e;
    resp_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b1, ADDR_W'(16 + a), {$urandom(), $urandom()}, 8'hFF);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    pops = 0; not_ready = 0; late = 0;
    for (int j = 0; j < 24; j++) begin
      if (j < 16) drive(1'b1, 1'b0, ADDR_W'(16 + j), '0, '0);
      else drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      if (j < 16 && t_ready !== 1'b1) not_ready++;
      if (t_pop === 1'b1) begin
        if (j != pops + 2) late++;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checks++; if (t_rdata !== e) begin errors++; $display("FAIL stream_resp%0d got %h want %h", pops, t_rdata, e); end
        end
        pops++;
      end
    end
    checks++; if (not_ready != 0) begin errors++; $display("FAIL stream_ready_drops got %0d want 0", not_ready); end
    checks++; if (late != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", late); end
    checks++; if (pops != 16) begin errors++; $display("FAIL stream_count got %0d want 16", pops); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] e;
    logic exp_ready;
    logic port_ok;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
            {$urandom(), $urandom()}, ($urandom_range(0, 3) == 0) ? '0 : MASK_W'($urandom()));
      resp_ready = 1'($urandom_range(0, 1));
      tick();
      exp_ready = (t_out < 2) || (t_pop === 1'b1);
      checks++; if (t_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, t_ready, exp_ready); end
      if (t_acc === 1'b1)
        port_ok = (t_en === 1'b1) && (t_wmode === t_w) && (t_addr === t_a) &&
                  (t_wmask === t_m) && (!t_w || t_wdata === t_d);
      else
        port_ok = (t_en === 1'b0);
      checks++; if (!port_ok) begin errors++; $display("FAIL rnd_port cyc %0d got en=%b wm=%b addr=%h want en=%b wm=%b addr=%h", c, t_en, t_wmode, t_addr, t_acc, t_w, t_a); end
      if (t_pop === 1'b1) begin
        if (expq.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_extra_resp got %h want none", t_rdata);
        end else begin
          e = expq.pop_front();
          checks++; if (t_rdata !== e) begin errors++; $display("FAIL rnd_resp cyc %0d got %h want %h", c, t_rdata, e); end
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (t_pop === 1'b1 && expq.size() > 0) begin
        e = expq.pop_front();
        checks++; if (t_rdata !== e) begin errors++; $display("FAIL rnd_drain got %h want %h", t_rdata, e); end
      end
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost_resp got %0d pending want 0", expq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] got;
    bit seen;
    // Reset during the sweep at address 200
    drive(1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (200) tick();
    checks++; if (t_addr !== 9'd199) begin errors++; $display("FAIL mid_sweep_addr got %0d want 199", t_addr); end
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (t_init_done !== 1'b0) begin errors++; $display("FAIL mid_sweep_init_done got %b want 0", t_init_done); end
    checks++; if (t_rvalid !== 1'b0) begin errors++; $display("FAIL mid_sweep_resp_valid got %b want 0", t_rvalid); end
    test_init_sweep();
    // Reset with a read in flight
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 9'h003, {$urandom(), $urandom()}, 8'hFF);
    tick();
    drive(1'b1, 1'b0, 9'h003, '0, '0);
    tick();
    checks++; if (t_acc !== 1'b1) begin errors++; $display("FAIL inflight_rd_accept got %b want 1", t_acc); end
    drive(1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    tick();
    expq.delete();
    tick();
    checks++; if (t_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_reset_resp_valid got %b want 0", t_rvalid); end
    checks++; if (t_init_done !== 1'b0) begin errors++; $display("FAIL inflight_reset_init_done got %b want 0", t_init_done); end
    test_init_sweep();
    // Re-swept location must read back as zero
    drive(1'b1, 1'b0, 9'h003, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    seen = 0; got = '1;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (t_pop === 1'b1) begin
        seen = 1; got = t_rdata;
        if (expq.size() > 0) e = expq.pop_front();
      end
    end
    checks++; if (!seen || got !== '0) begin errors++; $display("FAIL post_reset_zero got %h (seen %0d) want 0", got, seen); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = {$urandom(), $urandom()};
      ref_mem[i]  = '0;
    end
    reset_n = 1'b0;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_init_sweep();
    test_write_read();
    test_masked_write();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
